// File: rtl/delay_probe_if.sv
// delay_probe_if: probe-side handshake and delay-line bus for delay_probe
//   start   -> probe   request a measurement
//   rx_data -> probe   delay line output
//   tx_data <- probe   delay line input
//   busy, done, error, delay <- probe   measurement status and result
interface delay_probe_if #(
   parameter int WIDTH = 8,
   parameter int DW    = 3
);
   logic             start;
   logic [WIDTH-1:0] tx_data;
   logic [WIDTH-1:0] rx_data;
   logic             busy;
   logic             done;
   logic             error;
   logic [DW-1:0]    delay;
   modport master (input start, rx_data, output tx_data, busy, done, error, delay);
   modport slave  (output start, rx_data, input tx_data, busy, done, error, delay);
endinterface

// File: rtl/delay_probe.sv
// delay_probe: measures the cycle latency of an external delay line with a marker word
//   clk   rising-edge clock
//   reset asynchronous active-low clear
//   bus   delay_probe_if.master: start in, rx_data in, tx_data/busy/done/error/delay out
module delay_probe #(
   parameter int               WIDTH     = 8,
   parameter int               MAX_DELAY = 7,
   parameter logic [WIDTH-1:0] PATTERN   = 8'hA5
) (
   input logic           clk,
   input logic           reset,
   delay_probe_if.master bus
);
   localparam int DW = $clog2(MAX_DELAY + 1);
   typedef enum logic [1:0] {IDLE, FLUSH, SEND, WAIT} state_t;
   state_t        state, state_n;
   logic [DW-1:0] cnt, cnt_n, delay_q;
   logic          done_q, error_q;
   logic          at_max, chk, hit, bad, tout, fin;
   // cnt paces FLUSH, then counts latency from the SEND cycle
   always_comb begin
      at_max  = cnt == DW'(MAX_DELAY);
      chk     = state == SEND || state == WAIT;
      hit     = chk && bus.rx_data == PATTERN;
      bad     = chk && bus.rx_data != '0 && !hit;
      tout    = chk && bus.rx_data == '0 && at_max;
      fin     = hit || bad || tout;
      state_n = state;
      cnt_n   = '0;
      case (state)
         IDLE:    state_n = bus.start ? FLUSH : IDLE;
         FLUSH: begin
            state_n = at_max ? SEND : FLUSH;
            cnt_n   = at_max ? '0 : cnt + DW'(1);
         end
         default: begin
            state_n = fin ? IDLE : WAIT;
            cnt_n   = fin ? '0 : cnt + DW'(1);
         end
      endcase
   end
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state   <= IDLE;
         cnt     <= '0;
         done_q  <= 1'b0;
         error_q <= 1'b0;
         delay_q <= '0;
      end else begin
         state   <= state_n;
         cnt     <= cnt_n;
         done_q  <= fin;
         error_q <= fin ? !hit : (state == IDLE && bus.start) ? 1'b0 : error_q;
         if (fin) delay_q <= hit ? cnt : '0;
      end
   end
   always_comb begin
      bus.tx_data = state == SEND ? PATTERN : '0;
      bus.busy    = state != IDLE;
   end
   assign bus.done  = done_q;
   assign bus.error = error_q;
   assign bus.delay = delay_q;
endmodule

// File: tb/tb_delay_probe.sv
// tb_delay_probe: randomized self-checking bench for delay_probe against a latency model
module tb_delay_probe;
   localparam int MAXD = 7;
   logic       clk = 1'b0;
   logic       reset;
   logic       force_en, preload;
   int         dly;
   int         tests = 0, fails = 0;
   logic [7:0] stages [16];
   delay_probe_if #(.WIDTH(8), .DW(3)) bus ();
   delay_probe #(.WIDTH(8), .MAX_DELAY(MAXD), .PATTERN(8'hA5)) dut (.clk(clk), .reset(reset), .bus(bus));
   always #5 clk = ~clk;
   always @(posedge clk) begin
      if (preload) for (int i = 0; i < 16; i++) stages[i] <= 8'hA5;
      else begin
         stages[0] <= bus.tx_data;
         for (int i = 1; i < 16; i++) stages[i] <= stages[i-1];
      end
   end
   always_comb bus.rx_data = force_en ? 8'h5A : (dly == 0 ? bus.tx_data : stages[dly-1]);

   // latency in edges after the start edge, from the line delay and an optional corruption point
   function automatic void model(input int d, input int force_at, output int lat, output bit err, output int dl);
      int fe;
      if (d <= MAXD) begin lat = MAXD + 2 + d; err = 0; dl = d; end
      else begin lat = 2 * MAXD + 2; err = 1; dl = 0; end
      if (force_at >= 0) begin
         fe = (force_at + 1 < MAXD + 2) ? MAXD + 2 : force_at + 1;
         if (fe <= lat) begin lat = fe; err = 1; dl = 0; end
      end
   endfunction

   task automatic measure(input int d, input int force_at, input bit pre, output int lat,
                          output logic err, output logic [2:0] dl, output bit busy_bad);
      dly = d;
      @(negedge clk); bus.start = 1'b1; preload = pre;
      @(posedge clk); #1; bus.start = 1'b0; preload = 1'b0;
      lat = -1; err = 1'bx; dl = 'x; busy_bad = !bus.busy;
      for (int k = 1; k <= 40; k++) begin
         @(posedge clk); #1;
         if (bus.done) begin lat = k; err = bus.error; dl = bus.delay; busy_bad |= bus.busy; break; end
         if (!bus.busy) busy_bad = 1;
         if (k == force_at) force_en = 1'b1;
      end
      force_en = 1'b0;
      repeat (2) @(posedge clk);
   endtask

   task automatic test_reset();
      #1;
      tests++; if ({bus.tx_data, bus.busy, bus.done, bus.error, bus.delay} !== 14'd0) begin fails++; $display("FAIL reset_state got tx=%h busy=%b done=%b err=%b dly=%0d exp all 0", bus.tx_data, bus.busy, bus.done, bus.error, bus.delay); end
      @(negedge clk); reset = 1'b1;
   endtask

   task automatic test_sel();
      int el, edl, lat; bit ee, bb; logic e; logic [2:0] dl;
      for (int i = 0; i < 12; i++) begin
         int d = i < 4 ? i : $urandom_range(0, 8);
         model(d, -1, el, ee, edl);
         measure(d, -1, 0, lat, e, dl, bb);
         tests++; if (lat !== el) begin fails++; $display("FAIL sel%0d latency got %0d exp %0d", d, lat, el); end
         tests++; if (e !== ee) begin fails++; $display("FAIL sel%0d error got %b exp %b", d, e, ee); end
         tests++; if (dl !== 3'(edl)) begin fails++; $display("FAIL sel%0d delay got %0d exp %0d", d, dl, edl); end
         tests++; if (bb) begin fails++; $display("FAIL sel%0d busy got bad exp high until done then low", d); end
      end
   endtask

   task automatic test_timeout();
      int lat; bit bb; logic e; logic [2:0] dl;
      measure(8, -1, 0, lat, e, dl, bb);
      tests++; if ({lat, e, dl} !== {32'd16, 1'b1, 3'd0}) begin fails++; $display("FAIL timeout got lat=%0d err=%b dly=%0d exp 16/1/0", lat, e, dl); end
      measure(2, -1, 0, lat, e, dl, bb);
      tests++; if ({lat, e, dl} !== {32'd11, 1'b0, 3'd2}) begin fails++; $display("FAIL after_timeout got lat=%0d err=%b dly=%0d exp 11/0/2", lat, e, dl); end
   endtask

   task automatic test_corrupt();
      int el, edl, lat, d, fa; bit ee, bb; logic e; logic [2:0] dl;
      for (int i = 0; i < 4; i++) begin
         d = i == 0 ? 5 : $urandom_range(2, 7);
         fa = i == 0 ? 10 : $urandom_range(9, 8 + d);
         model(d, fa, el, ee, edl);
         measure(d, fa, 0, lat, e, dl, bb);
         tests++; if ({lat, e, dl} !== {el, ee, 3'(edl)}) begin fails++; $display("FAIL corrupt sel%0d at%0d got lat=%0d err=%b dly=%0d exp %0d/%b/%0d", d, fa, lat, e, dl, el, ee, edl); end
      end
   endtask

   task automatic test_preload();
      int lat; bit bb; logic e; logic [2:0] dl;
      measure(3, -1, 1, lat, e, dl, bb);
      tests++; if ({lat, e, dl} !== {32'd12, 1'b0, 3'd3}) begin fails++; $display("FAIL preload got lat=%0d err=%b dly=%0d exp 12/0/3", lat, e, dl); end
   endtask

   task automatic test_busy_start();
      int lat = -1, extra = 0;
      dly = 4;
      @(negedge clk); bus.start = 1'b1;
      @(posedge clk); #1; bus.start = 1'b0;
      for (int k = 1; k <= 40; k++) begin
         @(posedge clk); #1; bus.start = 1'b0;
         if (bus.done) begin lat = k; break; end
         if (k < 11) bus.start = 1'($urandom_range(0, 1));
      end
      for (int k = 0; k < 20; k++) begin @(posedge clk); #1; if (bus.done || bus.busy) extra++; end
      tests++; if (lat !== 13) begin fails++; $display("FAIL busy_start latency got %0d exp 13", lat); end
      tests++; if (extra !== 0) begin fails++; $display("FAIL busy_start extra activity got %0d exp 0", extra); end
   endtask

   task automatic test_back_to_back();
      int first = -1, second = -1; logic acc = 1'b0;
      dly = 2;
      @(negedge clk); bus.start = 1'b1;
      @(posedge clk);
      for (int k = 1; k <= 60; k++) begin
         @(posedge clk); #1;
         if (first > 0 && k == first + 1) begin acc = bus.busy; bus.start = 1'b0; end
         if (bus.done) begin if (first < 0) first = k; else begin second = k; break; end end
      end
      bus.start = 1'b0;
      tests++; if (first !== 11) begin fails++; $display("FAIL b2b first got %0d exp 11", first); end
      tests++; if (acc !== 1'b1) begin fails++; $display("FAIL b2b accept busy got %b exp 1", acc); end
      tests++; if (second !== 23) begin fails++; $display("FAIL b2b second got %0d exp 23", second); end
      repeat (2) @(posedge clk);
   endtask

   task automatic test_reset_mid();
      int dn = 0, lat; bit bb; logic e; logic [2:0] dl;
      dly = 3;
      @(negedge clk); bus.start = 1'b1;
      @(posedge clk); #1; bus.start = 1'b0;
      repeat (10) @(posedge clk);
      #2; reset = 1'b0; #1;
      tests++; if ({bus.tx_data, bus.busy, bus.done, bus.error, bus.delay} !== 14'd0) begin fails++; $display("FAIL reset_mid outputs got tx=%h busy=%b done=%b err=%b dly=%0d exp all 0", bus.tx_data, bus.busy, bus.done, bus.error, bus.delay); end
      for (int k = 0; k < 5; k++) begin @(posedge clk); #1; if (bus.done) dn++; end
      tests++; if (dn !== 0) begin fails++; $display("FAIL reset_mid done got %0d pulses exp 0", dn); end
      @(negedge clk); reset = 1'b1;
      measure(1, -1, 0, lat, e, dl, bb);
      tests++; if ({lat, e, dl} !== {32'd10, 1'b0, 3'd1}) begin fails++; $display("FAIL reset_mid after got lat=%0d err=%b dly=%0d exp 10/0/1", lat, e, dl); end
   endtask

   initial begin
      reset = 1'b0; bus.start = 1'b0; force_en = 1'b0; preload = 1'b0; dly = 0;
      repeat (20) @(posedge clk);
      test_reset();
      repeat (3) @(posedge clk);
      test_sel();
      test_timeout();
      test_preload();
      test_busy_start();
      test_back_to_back();
      test_corrupt();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end
endmodule

// File: doc/delay_probe.md
# delay_probe

Calibration block that measures the latency of an external 8-bit delay line (0..MAX_DELAY clock stages, including a 0-cycle combinational pass-through). It drives the line input, watches the line output, and reports the cycles between launching a marker word and seeing it return. It sits at the driving/receiving end of the selectable-tap register pipeline and is used at bring-up to determine which tap is in effect.

## Interface
- WIDTH, 8, data width of the line under test
- MAX_DELAY, 7, largest delay measured; DW = $clog2(MAX_DELAY+1)
- PATTERN, 8'hA5, marker word; must be nonzero
- clk  input  1  clock, all state changes on rising edge
- reset  input  1  asynchronous, active-low; clears all state and outputs
- start  input  1  request a measurement; sampled only when busy=0
- tx_data  output  WIDTH  drives delay line input
- rx_data  input  WIDTH  delay line output
- busy  output  1  measurement in progress
- done  output  1  one-cycle pulse, measurement finished (pass or fail)
- error  output  1  last measurement failed; held until next accepted start
- delay  output  DW  measured delay; valid when done=1 and error=0; held until next done

## Operation
- States: IDLE, FLUSH, SEND, WAIT.
- IDLE: tx_data=0, busy=0. start=1 at an edge -> FLUSH, cnt<=0, error<=0, busy<=1.
- FLUSH: tx_data=0 for exactly MAX_DELAY+1 cycles to purge stale line contents; rx_data ignored. Then -> SEND.
- SEND: one cycle, tx_data=PATTERN, cnt=0.
- WAIT: tx_data=0; cnt increments by 1 per cycle.
- Match check at every edge in SEND and WAIT, on rx_data during the cycle just ending:
  - rx_data==PATTERN: delay<=cnt, done<=1, error<=0 -> IDLE.
  - rx_data!=0 and !=PATTERN (corruption): error<=1, done<=1, delay<=0 -> IDLE.
  - rx_data==0 and cnt==MAX_DELAY (timeout): error<=1, done<=1, delay<=0 -> IDLE.
  - otherwise stay/advance (SEND -> WAIT).
- Corruption is checked before timeout. A match in SEND yields delay=0, covering the combinational tap.
- tx_data is decoded from the state register only: no glitches and no dependence on rx_data.
- cnt is DW bits and never wraps; timeout fires at MAX_DELAY.
- start while busy=1 is ignored; it is not queued.
- start may be asserted on the same edge that done is produced. It is accepted on the following edge, from IDLE.

## Timing
- Reset (async, any state, including mid-measurement): state=IDLE, tx_data=0, busy=0, done=0, error=0, delay=0, cnt=0. Effective immediately; the first start is accepted on the first edge after reset deasserts.
- start sampled at edge E0. busy=1 from E0 through the edge that produces done, then busy=0. busy and done are never both 1.
- FLUSH occupies cycles E0..E0+MAX_DELAY+1. The SEND cycle ends at edge E0+MAX_DELAY+2.
- For a true line delay d: the match is sampled at edge E0+MAX_DELAY+2+d, and done=1 for the cycle after it. With defaults, done rises 9+d edges after start.
- Timeout: done rises at edge E0+2·MAX_DELAY+2 (16 with defaults).
- done is a single-cycle pulse. error and delay are registered and stable between done pulses.

## Test plan
- Delay line with sel=0..3, one start each -> done 9+sel edges after start, delay=sel, error=0, busy low on the done cycle.
- Line replaced by an 8-stage delay (exceeds MAX_DELAY=7) -> done at edge 16, error=1, delay=0. A following measurement with sel=2 clears error and returns delay=2.
- Line output forced to 8'h5A during WAIT -> done at the first corrupted cycle's edge, error=1, delay=0.
- Line preloaded with 8'hA5 in all stages before start -> FLUSH purges it; the result is still the correct sel (e.g. sel=3 -> delay=3), with no early match.
- start pulsed repeatedly while busy -> ignored, single done. start held high across done -> new measurement accepted on the edge after done.
- reset asserted mid-WAIT -> all outputs 0 asynchronously, no done. After release, start with sel=1 -> delay=1 at edge 10.
